// File: rtl/pipe_skid_reg.sv
// Registered valid/ready pipeline stage with a one-entry skid buffer and synchronous flush.
// All handshake outputs and the head data word come straight from flops.
module pipe_skid_reg #(
  parameter int unsigned  W        = 32,
  parameter logic [W-1:0] RST_DATA = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     main_q, main_d;
  logic [W-1:0]     skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state and storage update; main always holds the oldest word.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_valid) begin
          main_d  = in_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (out_ready) begin
          if (in_valid) begin
            main_d = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (in_valid) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Squash wins over everything; stale data is masked by out_valid.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // Handshake flags and occupancy are decoded from the next state so they stay registered.
  always_comb begin
    out_valid_d = 1'b0;
    in_ready_d  = 1'b1;
    count_d     = CNT_W'(0);
    unique case (state_d)
      ST_BUSY: begin
        out_valid_d = 1'b1;
        count_d     = CNT_W'(1);
      end
      ST_FULL: begin
        out_valid_d = 1'b1;
        in_ready_d  = 1'b0;
        count_d     = CNT_W'(2);
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        count_d     = CNT_W'(0);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= RST_DATA;
      skid_q      <= RST_DATA;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= CNT_W'(0);
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a 2-deep queue model predicts every output
// after each rising edge; directed scenarios followed by a long random run.
module tb_pipe_skid_reg;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  int unsigned  n_pushed = 0;
  int unsigned  n_popped = 0;
  logic [W-1:0] sb[$];

  pipe_skid_reg #(.W(W), .RST_DATA('0)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Compare all outputs against the model queue; head of queue is the expected out_data.
  task automatic check_outputs();
    int unsigned sz;
    sz = sb.size();
    check_eq("count", W'(count), W'(sz));
    check_eq("out_valid", W'(out_valid), W'(sz > 0));
    check_eq("in_ready", W'(in_ready), W'(sz < 2));
    check_eq("in_ready_vs_count", W'(in_ready), W'(count < 2'd2));
    if (sz > 0) check_eq("out_data", out_data, sb[0]);
  endtask

  // One cycle: check state after the last edge, drive new inputs, advance the model.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    logic outx, inx;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    outx = (sb.size() > 0) && ordy;
    inx  = v && (sb.size() < 2);
    if (outx) begin
      void'(sb.pop_front());
      n_popped++;
    end
    if (fl) sb.delete();
    else if (inx) begin
      sb.push_back(d);
      n_pushed++;
    end
  endtask

  initial begin
    // Reset held across the first edge.
    @(negedge clk);
    check_outputs();
    check_eq("rst_out_data", out_data, '0);
    rst = 1'b0;

    // Streaming at full throughput.
    for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Backpressure: fill, hold, then drain 5 then 1.
    cycle(1'b1, 32'd5, 1'b0, 1'b0);
    cycle(1'b1, 32'd1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Full hold: the word offered while full must never appear.
    cycle(1'b1, 32'd5, 1'b0, 1'b0);
    cycle(1'b1, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush while full with a word offered in the same cycle.
    cycle(1'b1, 32'd7, 1'b0, 1'b0);
    cycle(1'b1, 32'd8, 1'b0, 1'b0);
    cycle(1'b1, 32'd9, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Async reset while full, observed before the next edge.
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    check_eq("arst_out_valid", W'(out_valid), W'(0));
    check_eq("arst_in_ready", W'(in_ready), W'(1));
    check_eq("arst_count", W'(count), W'(0));
    check_eq("arst_out_data", out_data, '0);
    in_valid = 1'b1;
    in_data  = 32'h77;
    @(negedge clk);
    check_outputs();
    rst      = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b0;
    cycle(1'b1, 32'h33, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flush.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) < 3));
    end

    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check_outputs();
    check_eq("drained", W'(sb.size()), W'(0));
    check_eq("pop_le_push", W'(n_popped <= n_pushed), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
